// File: rtl/rs_issue_scheduler_pkg.sv
// rs_issue_scheduler_pkg
//   Shared sizing constants, the issue packet type and small helpers for the
//   reservation-station issue scheduler.
//   Contents:
//     RS_SIZE / DP_WIDTH / IS_WIDTH / AGE_W  array and slot geometry
//     IDX_W / CNT_W / POS_W                  derived index/count widths
//     rs_issue_packet_t                      {valid, idx} for one issue slot
//     sat_inc, popcount_rs, popcount_dp, onehot_to_idx  helper functions
package rs_issue_scheduler_pkg;

    localparam int RS_SIZE  = 16;
    localparam int DP_WIDTH = 3;
    localparam int IS_WIDTH = 3;
    localparam int AGE_W    = 4;

    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = $clog2(RS_SIZE) + 1;
    localparam int POS_W = 2;

    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rs_issue_packet_t;

    // Saturating increment: an age that has reached AGE_MAX stays there so a
    // long-waiting line never wraps around and loses priority.
    function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
        logic [AGE_W-1:0] r;
        r = (a == AGE_MAX) ? a : (a + {{(AGE_W-1){1'b0}}, 1'b1});
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] popcount_rs(input logic [RS_SIZE-1:0] v);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int i = 0; i < RS_SIZE; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] popcount_dp(input logic [DP_WIDTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int i = 0; i < DP_WIDTH; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    // OR-reduction encoder; the argument is one-hot or zero.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [RS_SIZE-1:0] oh);
        logic [IDX_W-1:0] r;
        r = {IDX_W{1'b0}};
        for (int i = 0; i < RS_SIZE; i++) begin
            r = r | (oh[i] ? IDX_W'(i) : {IDX_W{1'b0}});
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_age_picker.sv
// rs_age_picker
//   Combinational oldest-first picker. Among the lines flagged in cand, returns
//   a one-hot grant for the line with the largest age; equal ages resolve to
//   the lowest index.
//   Ports:
//     cand   in   RS_SIZE            candidate lines
//     age    in   RS_SIZE x AGE_W    per-line age
//     grant  out  RS_SIZE            one-hot winner (zero when no candidate)
//     valid  out  1                  a winner exists
module rs_age_picker
    import rs_issue_scheduler_pkg::*;
(
    input  logic [RS_SIZE-1:0]            cand,
    input  logic [RS_SIZE-1:0][AGE_W-1:0] age,
    output logic [RS_SIZE-1:0]            grant,
    output logic                          valid
);

    logic [AGE_W-1:0] best_age_s;
    logic [IDX_W-1:0] best_idx_s;
    logic             found_s;
    logic             take_s;

    // Linear scan; strict '>' keeps the earlier (lower) index on a tie.
    always_comb begin
        best_age_s = {AGE_W{1'b0}};
        best_idx_s = {IDX_W{1'b0}};
        found_s    = 1'b0;
        take_s     = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            take_s     = cand[i] & (~found_s | (age[i] > best_age_s));
            best_age_s = take_s ? age[i] : best_age_s;
            best_idx_s = take_s ? IDX_W'(i) : best_idx_s;
            found_s    = found_s | take_s;
        end
        grant             = {RS_SIZE{1'b0}};
        grant[best_idx_s] = found_s;
        valid             = found_s;
    end

endmodule

// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler
//   Controller for the reservation-station line array. Allocates free lines
//   to valid dispatch slots, picks up to IS_WIDTH ready lines oldest-first,
//   clears them and issues their indices one cycle later. Keeps a saturating
//   age per line and flushes everything on squash.
//   Ports:
//     clock, reset(active-low async), squash
//     dp_valid[DP_WIDTH]          dispatch slot valid
//     line_busy/line_ready[RS]    status from each line
//     fu_ready[IS_WIDTH]          issue slot may accept
//     line_enable/line_pos/line_clear   per-line strobes (combinational)
//     dp_stall, free_count        allocation status (combinational)
//     issue_valid/issue_idx       registered issue packets
module rs_issue_scheduler
    import rs_issue_scheduler_pkg::*;
(
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            squash,
    input  logic [DP_WIDTH-1:0]             dp_valid,
    input  logic [RS_SIZE-1:0]              line_busy,
    input  logic [RS_SIZE-1:0]              line_ready,
    input  logic [IS_WIDTH-1:0]             fu_ready,
    output logic [RS_SIZE-1:0]              line_enable,
    output logic [RS_SIZE-1:0][POS_W-1:0]   line_pos,
    output logic [RS_SIZE-1:0]              line_clear,
    output logic                            dp_stall,
    output logic [CNT_W-1:0]                free_count,
    output logic [IS_WIDTH-1:0]             issue_valid,
    output logic [IS_WIDTH-1:0][IDX_W-1:0]  issue_idx
);

    logic [RS_SIZE-1:0][AGE_W-1:0]  age_q, age_d;
    rs_issue_packet_t [IS_WIDTH-1:0] issue_pkt_q, issue_pkt_d;

    logic [IS_WIDTH-1:0][RS_SIZE-1:0] cand_chain_s;
    logic [IS_WIDTH-1:0][RS_SIZE-1:0] pick_cand_s;
    logic [IS_WIDTH-1:0][RS_SIZE-1:0] grant_s;
    logic [IS_WIDTH-1:0]              pick_valid_s;
    logic [RS_SIZE-1:0]               grant_any_s;
    logic [RS_SIZE-1:0]               free_s;
    logic [CNT_W-1:0]                 dp_count_s;

    // While reset is held or on squash nothing is eligible for issue.
    assign cand_chain_s[0] = line_busy & line_ready & {RS_SIZE{~squash & reset}};

    // One picker per issue slot; a slot whose FU is not ready sees no
    // candidates, so the full set passes on to the next slot.
    for (genvar k = 0; k < IS_WIDTH; k++) begin : g_pick
        assign pick_cand_s[k] = cand_chain_s[k] & {RS_SIZE{fu_ready[k]}};
        rs_age_picker u_picker (
            .cand  (pick_cand_s[k]),
            .age   (age_q),
            .grant (grant_s[k]),
            .valid (pick_valid_s[k])
        );
        if (k < IS_WIDTH - 1) begin : g_next
            assign cand_chain_s[k+1] = cand_chain_s[k] & ~grant_s[k];
        end
    end

    // Merge slot grants and form the per-line clear strobe.
    always_comb begin
        grant_any_s = {RS_SIZE{1'b0}};
        for (int k = 0; k < IS_WIDTH; k++) begin
            grant_any_s = grant_any_s | grant_s[k];
        end
        if (!reset) begin
            line_clear = {RS_SIZE{1'b0}};
        end else if (squash) begin
            line_clear = {RS_SIZE{1'b1}};
        end else begin
            line_clear = grant_any_s;
        end
    end

    // A line being cleared this cycle is not handed out again until next cycle.
    assign free_s     = ~line_busy & ~line_clear;
    assign free_count = popcount_rs(free_s);
    assign dp_count_s = popcount_dp(dp_valid);
    assign dp_stall   = (dp_count_s > free_count);

    // Allocation: walk lines in ascending order, giving each free line the
    // lowest still-unserved valid dispatch slot. All-or-nothing via dp_stall.
    always_comb begin
        logic [DP_WIDTH-1:0] remaining_s;
        logic [DP_WIDTH-1:0] slot_mask_s;
        logic [POS_W-1:0]    slot_s;
        logic                found_s;
        logic                alloc_ok_s;
        logic                take_s;
        line_enable = {RS_SIZE{1'b0}};
        line_pos    = {RS_SIZE*POS_W{1'b0}};
        remaining_s = dp_valid;
        alloc_ok_s  = reset & ~squash & ~dp_stall;
        for (int i = 0; i < RS_SIZE; i++) begin
            slot_s      = {POS_W{1'b0}};
            slot_mask_s = {DP_WIDTH{1'b0}};
            found_s     = 1'b0;
            for (int k = 0; k < DP_WIDTH; k++) begin
                slot_mask_s[k] = remaining_s[k] & ~found_s;
                slot_s         = slot_mask_s[k] ? POS_W'(k) : slot_s;
                found_s        = found_s | remaining_s[k];
            end
            take_s         = alloc_ok_s & free_s[i] & found_s;
            line_enable[i] = take_s;
            line_pos[i]    = take_s ? slot_s : {POS_W{1'b0}};
            remaining_s    = remaining_s & ~(slot_mask_s & {DP_WIDTH{take_s}});
        end
    end

    // Next-state ages: restart on allocate/clear/squash, count while busy.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            if (line_enable[i] | line_clear[i] | squash) begin
                age_d[i] = {AGE_W{1'b0}};
            end else if (line_busy[i]) begin
                age_d[i] = sat_inc(age_q[i]);
            end else begin
                age_d[i] = age_q[i];
            end
        end
    end

    // Next issue packets from the picker chain.
    always_comb begin
        for (int k = 0; k < IS_WIDTH; k++) begin
            issue_pkt_d[k].valid = pick_valid_s[k];
            issue_pkt_d[k].idx   = onehot_to_idx(grant_s[k]);
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            age_q       <= {RS_SIZE*AGE_W{1'b0}};
            issue_pkt_q <= {IS_WIDTH*(IDX_W+1){1'b0}};
        end else begin
            age_q       <= age_d;
            issue_pkt_q <= issue_pkt_d;
        end
    end

    // Unpack registered issue packets onto the output ports.
    always_comb begin
        for (int k = 0; k < IS_WIDTH; k++) begin
            issue_valid[k] = issue_pkt_q[k].valid;
            issue_idx[k]   = issue_pkt_q[k].idx;
        end
    end

endmodule
